// File: rtl/uart_pkg.sv
// Shared constants, state encoding and helpers for the UART receive path.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam int OVS_NORM = 16;
  localparam int OVS_2X   = 8;

  localparam logic [3:0] WL_MIN = 4'd5;
  localparam logic [3:0] WL_MAX = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  function automatic logic [3:0] clamp_wl(input logic [3:0] w);
    if (w < WL_MIN) return WL_MIN;
    if (w > WL_MAX) return WL_MAX;
    return w;
  endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchronizer plus one extra stage so callers can see the previous
// synchronized value and derive edges from it.
module uart_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic prev
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign prev = s3;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 16x/8x oversampled, majority-vote bit decisions, one-entry
// holding register with frame/parity/overrun status.
module uart_receiver
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rxen,
  input  logic       rx,
  input  logic       rd,
  input  logic [3:0] wordlen,
  input  logic       u2x,
  input  logic [1:0] parity,
  input  logic       stopbits,
  input  logic       mode,
  output logic [8:0] data,
  output logic       charreceived,
  output logic       frameerror,
  output logic       parityerror,
  output logic       receiveoverrun
);

  logic rx_s, rx_p, rd_s, rd_p;
  logic rx_fall, rd_ev;

  uart_sync_edge #(.RST_VAL(1'b1)) u_rx_sync (
    .clk(clk), .rst(rst), .din(rx), .q(rx_s), .prev(rx_p)
  );
  uart_sync_edge #(.RST_VAL(1'b0)) u_rd_sync (
    .clk(clk), .rst(rst), .din(rd), .q(rd_s), .prev(rd_p)
  );

  assign rx_fall = rx_p & ~rx_s;
  assign rd_ev   = rd_s ^ rd_p;

  // Only asynchronous framing exists; the reserved mode input is ignored.
  logic mode_unused;
  assign mode_unused = mode;

  state_t     state, state_nx;
  logic [3:0] cnt, bitcnt, wl_r, n_last, dec_pt;
  logic [1:0] par_r;
  logic       two_stop_r, u2x_r;
  logic [8:0] shreg;
  logic       par_acc, stop_err, smp_a, smp_b;
  logic       at_dec, at_end, vote, complete, fe_nx, pe_nx;

  assign n_last = u2x_r ? 4'(OVS_2X - 1) : 4'(OVS_NORM - 1);
  assign dec_pt = u2x_r ? 4'd5 : 4'd9;
  assign at_dec = (cnt == dec_pt);
  assign at_end = (cnt == n_last);
  assign vote   = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    complete = 1'b0;
    case (state)
      S_IDLE:   if (rxen && rx_fall) state_nx = S_START;
      S_START: begin
        if (at_dec && vote) state_nx = S_IDLE;
        else if (at_end)    state_nx = S_DATA;
      end
      S_DATA: begin
        if (at_end && bitcnt == wl_r - 4'd1)
          state_nx = (par_r == PAR_EVEN || par_r == PAR_ODD) ? S_PARITY : S_STOP1;
      end
      S_PARITY: if (at_end) state_nx = S_STOP1;
      S_STOP1: begin
        if (at_dec && !two_stop_r) begin
          complete = 1'b1;
          state_nx = S_IDLE;
        end else if (at_end) begin
          state_nx = S_STOP2;
        end
      end
      S_STOP2: begin
        if (at_dec) begin
          complete = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default:  state_nx = S_IDLE;
    endcase
    if (!rxen) begin
      state_nx = S_IDLE;
      complete = 1'b0;
    end
  end

  // Error values as they stand at the final stop-bit decision.
  always_comb begin
    fe_nx = (state == S_STOP2) ? (stop_err | ~vote) : ~vote;
    case (par_r)
      PAR_EVEN: pe_nx = par_acc;
      PAR_ODD:  pe_nx = ~par_acc;
      default:  pe_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      bitcnt     <= '0;
      wl_r       <= WL_MIN;
      par_r      <= PAR_NONE;
      two_stop_r <= 1'b0;
      u2x_r      <= 1'b0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      stop_err   <= 1'b0;
      smp_a      <= 1'b1;
      smp_b      <= 1'b1;
    end else if (state == S_IDLE) begin
      cnt <= '0;
      if (rx_fall) begin
        wl_r       <= clamp_wl(wordlen);
        par_r      <= parity;
        two_stop_r <= stopbits;
        u2x_r      <= u2x;
        shreg      <= '0;
        bitcnt     <= '0;
        par_acc    <= 1'b0;
        stop_err   <= 1'b0;
      end
    end else begin
      cnt <= at_end ? 4'd0 : cnt + 4'd1;
      if (cnt == dec_pt - 4'd2) smp_a <= rx_s;
      if (cnt == dec_pt - 4'd1) smp_b <= rx_s;
      if (at_dec) begin
        case (state)
          S_DATA: begin
            shreg[bitcnt] <= vote;
            par_acc       <= par_acc ^ vote;
          end
          S_PARITY: par_acc  <= par_acc ^ vote;
          S_STOP1:  stop_err <= ~vote;
          default: ;
        endcase
      end
      if (at_end && state == S_DATA) bitcnt <= bitcnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data           <= '0;
      charreceived   <= 1'b0;
      frameerror     <= 1'b0;
      parityerror    <= 1'b0;
      receiveoverrun <= 1'b0;
    end else if (complete) begin
      data         <= shreg;
      frameerror   <= fe_nx;
      parityerror  <= pe_nx;
      charreceived <= 1'b1;
      // A read landing on the completion cycle consumes the old character.
      if (rd_ev)             receiveoverrun <= 1'b0;
      else if (charreceived) receiveoverrun <= 1'b1;
    end else if (rd_ev) begin
      charreceived   <= 1'b0;
      receiveoverrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames driven bit by bit, expected
// status hand-computed per scenario.
module tb_uart_receiver;

  logic       clk, rst, rxen, rx, rd, u2x, stopbits, mode;
  logic [3:0] wordlen;
  logic [1:0] parity;
  logic [8:0] data;
  logic       charreceived, frameerror, parityerror, receiveoverrun;

  int checks = 0;
  int errors = 0;

  uart_receiver dut (
    .clk(clk), .rst(rst), .rxen(rxen), .rx(rx), .rd(rd),
    .wordlen(wordlen), .u2x(u2x), .parity(parity), .stopbits(stopbits),
    .mode(mode), .data(data), .charreceived(charreceived),
    .frameerror(frameerror), .parityerror(parityerror),
    .receiveoverrun(receiveoverrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_frame(input logic [8:0] d, input int wl, input int pbit,
                            input int nstop, input logic stop1, input int n);
    rx = 1'b0;
    repeat (n) @(negedge clk);
    for (int i = 0; i < wl; i++) begin
      rx = d[i];
      repeat (n) @(negedge clk);
    end
    if (pbit >= 0) begin
      rx = pbit[0];
      repeat (n) @(negedge clk);
    end
    rx = stop1;
    repeat (n) @(negedge clk);
    if (nstop == 2) begin
      rx = 1'b1;
      repeat (n) @(negedge clk);
    end
    rx = 1'b1;
    repeat (3 * n) @(negedge clk);
  endtask

  task automatic do_read();
    rd = ~rd;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; rxen = 1'b1; rx = 1'b1; rd = 1'b0; mode = 1'b0;
    wordlen = 4'd8; u2x = 1'b0; parity = 2'd1; stopbits = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (data !== 9'h000) begin errors++; $display("FAIL reset_data got %h exp 000", data); end
    checks++; if (charreceived !== 1'b0) begin errors++; $display("FAIL reset_cr got %b exp 0", charreceived); end
    checks++; if (frameerror !== 1'b0) begin errors++; $display("FAIL reset_fe got %b exp 0", frameerror); end
    checks++; if (parityerror !== 1'b0) begin errors++; $display("FAIL reset_pe got %b exp 0", parityerror); end
    checks++; if (receiveoverrun !== 1'b0) begin errors++; $display("FAIL reset_ov got %b exp 0", receiveoverrun); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_8e1_good();
    send_frame(9'h047, 8, 0, 1, 1'b1, 16);
    checks++; if (data !== 9'h047) begin errors++; $display("FAIL 8e1_data got %h exp 047", data); end
    checks++; if (charreceived !== 1'b1) begin errors++; $display("FAIL 8e1_cr got %b exp 1", charreceived); end
    checks++; if (parityerror !== 1'b0) begin errors++; $display("FAIL 8e1_pe got %b exp 0", parityerror); end
    checks++; if (frameerror !== 1'b0) begin errors++; $display("FAIL 8e1_fe got %b exp 0", frameerror); end
    checks++; if (receiveoverrun !== 1'b0) begin errors++; $display("FAIL 8e1_ov got %b exp 0", receiveoverrun); end
    do_read();
    checks++; if (charreceived !== 1'b0) begin errors++; $display("FAIL 8e1_rd_cr got %b exp 0", charreceived); end
    checks++; if (data !== 9'h047) begin errors++; $display("FAIL 8e1_rd_data got %h exp 047", data); end
  endtask

  task automatic test_parity_err();
    send_frame(9'h047, 8, 1, 1, 1'b1, 16);
    checks++; if (data !== 9'h047) begin errors++; $display("FAIL perr_data got %h exp 047", data); end
    checks++; if (parityerror !== 1'b1) begin errors++; $display("FAIL perr_pe got %b exp 1", parityerror); end
    do_read();
    checks++; if (parityerror !== 1'b1) begin errors++; $display("FAIL perr_pe_after_rd got %b exp 1", parityerror); end
    send_frame(9'h047, 8, 0, 1, 1'b1, 16);
    checks++; if (parityerror !== 1'b0) begin errors++; $display("FAIL perr_clear got %b exp 0", parityerror); end
    do_read();
  endtask

  task automatic test_frame_err();
    parity = 2'd0;
    @(negedge clk);
    send_frame(9'h055, 8, -1, 1, 1'b0, 16);
    checks++; if (frameerror !== 1'b1) begin errors++; $display("FAIL ferr_fe got %b exp 1", frameerror); end
    checks++; if (charreceived !== 1'b1) begin errors++; $display("FAIL ferr_cr got %b exp 1", charreceived); end
    checks++; if (data !== 9'h055) begin errors++; $display("FAIL ferr_data got %h exp 055", data); end
    do_read();
    checks++; if (frameerror !== 1'b1) begin errors++; $display("FAIL ferr_fe_after_rd got %b exp 1", frameerror); end
    send_frame(9'h0A3, 8, -1, 1, 1'b1, 16);
    checks++; if (frameerror !== 1'b0) begin errors++; $display("FAIL ferr_clear got %b exp 0", frameerror); end
    checks++; if (data !== 9'h0A3) begin errors++; $display("FAIL ferr_next_data got %h exp 0a3", data); end
    do_read();
  endtask

  task automatic test_overrun();
    send_frame(9'h011, 8, -1, 1, 1'b1, 16);
    checks++; if (receiveoverrun !== 1'b0) begin errors++; $display("FAIL ovr_first got %b exp 0", receiveoverrun); end
    send_frame(9'h022, 8, -1, 1, 1'b1, 16);
    checks++; if (receiveoverrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", receiveoverrun); end
    checks++; if (data !== 9'h022) begin errors++; $display("FAIL ovr_data got %h exp 022", data); end
    checks++; if (charreceived !== 1'b1) begin errors++; $display("FAIL ovr_cr got %b exp 1", charreceived); end
    do_read();
    checks++; if (charreceived !== 1'b0) begin errors++; $display("FAIL ovr_rd_cr got %b exp 0", charreceived); end
    checks++; if (receiveoverrun !== 1'b0) begin errors++; $display("FAIL ovr_rd_ov got %b exp 0", receiveoverrun); end
  endtask

  task automatic test_false_start();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    checks++; if (data !== 9'h022) begin errors++; $display("FAIL fstart_data got %h exp 022", data); end
    checks++; if (charreceived !== 1'b0) begin errors++; $display("FAIL fstart_cr got %b exp 0", charreceived); end
    checks++; if (frameerror !== 1'b0) begin errors++; $display("FAIL fstart_fe got %b exp 0", frameerror); end
    checks++; if (receiveoverrun !== 1'b0) begin errors++; $display("FAIL fstart_ov got %b exp 0", receiveoverrun); end
  endtask

  task automatic test_reset_mid();
    logic [8:0] v;
    send_frame(9'h033, 8, -1, 1, 1'b1, 16);
    checks++; if (charreceived !== 1'b1) begin errors++; $display("FAIL rmid_pre_cr got %b exp 1", charreceived); end
    v = 9'h05A;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = v[i];
      repeat (16) @(negedge clk);
    end
    rst = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (data !== 9'h000) begin errors++; $display("FAIL rmid_data got %h exp 000", data); end
    checks++; if (charreceived !== 1'b0) begin errors++; $display("FAIL rmid_cr got %b exp 0", charreceived); end
    send_frame(9'h05A, 8, -1, 1, 1'b1, 16);
    checks++; if (data !== 9'h05A) begin errors++; $display("FAIL rmid_after_data got %h exp 05a", data); end
    checks++; if (charreceived !== 1'b1) begin errors++; $display("FAIL rmid_after_cr got %b exp 1", charreceived); end
    do_read();
  endtask

  task automatic test_9bit_u2x();
    wordlen = 4'd9; parity = 2'd2; stopbits = 1'b1; u2x = 1'b1;
    @(negedge clk);
    send_frame(9'h1A5, 9, 0, 2, 1'b1, 8);
    checks++; if (data !== 9'h1A5) begin errors++; $display("FAIL 9b_data got %h exp 1a5", data); end
    checks++; if (charreceived !== 1'b1) begin errors++; $display("FAIL 9b_cr got %b exp 1", charreceived); end
    checks++; if (parityerror !== 1'b0) begin errors++; $display("FAIL 9b_pe got %b exp 0", parityerror); end
    checks++; if (frameerror !== 1'b0) begin errors++; $display("FAIL 9b_fe got %b exp 0", frameerror); end
    checks++; if (receiveoverrun !== 1'b0) begin errors++; $display("FAIL 9b_ov got %b exp 0", receiveoverrun); end
  endtask

  initial begin
    test_reset();
    test_8e1_good();
    test_parity_err();
    test_frame_err();
    test_overrun();
    test_false_start();
    test_reset_mid();
    test_9bit_u2x();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Asynchronous UART receive block with a one-character holding register, configurable frame format and error flags. It oversamples the serial input at 16x (or 8x in double-speed mode) and is clocked from the system's baud-rate-derived peripheral clock. Receive status (character ready, frame/parity/overrun errors) is exported to the surrounding control logic.

## Interface
Parameters: none; frame format comes from static configuration ports.

Ports:
- clk  in  1  peripheral clock, 16x baud (u2x=0) or 8x baud (u2x=1).
- rst  in  1  reset. One clock; reset is synchronous and active-low.
- rxen  in  1  receiver enable; 0 holds receiver idle.
- rx  in  1  serial input, idle high.
- rd  in  1  read strobe; each transition (rise or fall) is one read event.
- wordlen  in  4  data bits per character, 5..9; <5 treated as 5, >9 as 9.
- u2x  in  1  0 = 16x oversampling, 1 = 8x.
- parity  in  2  0 none, 1 even, 2 odd, 3 treated as none.
- stopbits  in  1  0 one stop bit, 1 two stop bits.
- mode  in  1  0 asynchronous; 1 reserved, behaves as 0.
- data  out  9  last received character, LSB-aligned, unused upper bits 0.
- charreceived  out  1  holding register full.
- frameerror  out  1  stop-bit error of last character.
- parityerror  out  1  parity error of last character.
- receiveoverrun  out  1  character completed while holding register full.

## Operation
- rx and rd pass through 2-FF synchronizers; rd event = synchronized value differs from its previous value.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: on synchronized rx falling edge (and rxen=1) reset sample counter, go START.
- Bit sampling: counter runs 0..N-1 (N=16 or 8); bit value = majority of samples 7,8,9 (N=16) or 3,4,5 (N=8); bit decided at sample 9 / 5.
- START: decided value 1 -> false start, return IDLE, no flags change. Else DATA.
- DATA: shift wordlen bits LSB first; then PARITY if parity in {1,2}, else STOP1.
- PARITY: even -> error if XOR(data bits, parity bit)=1; odd -> error if it is 0.
- STOP1: sample; if stopbits=1 go STOP2 else complete. STOP2: sample, complete.
- Completion (at stop-bit decision, returns to IDLE immediately for resync): data <= received bits; frameerror <= any stop sample 0; parityerror <= computed error (0 if parity none); if charreceived already 1 and no simultaneous rd event, receiveoverrun <= 1; charreceived <= 1. New character always overwrites data.
- rd event: charreceived <= 0, receiveoverrun <= 0. Same cycle as completion: completion sets charreceived=1, overrun not set.
- rxen=0: state forced IDLE, partial frame discarded, outputs hold.
- frameerror/parityerror update only at completion; rd does not clear them.

## Timing
- Reset values: data=0, charreceived=0, frameerror=0, parityerror=0, receiveoverrun=0, state IDLE, synchronizers = 1 (rx), 0 (rd).
- Reset mid-frame aborts reception; first edge after release restarts cleanly.
- Flags valid the cycle after the last stop-bit decision (registered outputs).
- Latency from rx falling edge to charreceived ≈ 2 (sync) + N*(frame_bits-1) + decision offset (9 or 5) + 1 cycles.
- rd event takes effect 3 cycles after the rd transition; rd pulses shorter than one clk may be missed (caller guarantees ≥2 clk hold).
- Parity/wordlen/stopbits/u2x sampled at START; changes mid-frame ignored.

## Structure
- Shared package uart_pkg: parity encodings (NONE, EVEN, ODD), oversample constants (16, 8), wordlen min/max (5, 9), state enum.
- One sub-module: uart_sync_edge (2-FF synchronizer with edge detect), instanced for rx and rd.

## Test plan
- 8E1, u2x=0: send 0x47 with parity bit 0 -> data=0x047, charreceived=1, all errors 0; toggle rd -> charreceived=0.
- 8E1: send 0x47 with parity bit 1 -> data=0x047, parityerror=1; next good frame -> parityerror=0.
- 8N1: send 0x55 with stop bit 0 -> frameerror=1, charreceived=1; valid following frame clears frameerror.
- 8N1: two frames 0x11 then 0x22 without rd -> receiveoverrun=1, data=0x022; one rd transition -> charreceived=0, receiveoverrun=0.
- rx low for 4 clk then high (u2x=0) -> no completion, all outputs unchanged; reset asserted mid-frame -> all outputs 0.
- 9-bit, odd parity, two stops, u2x=1: send 0x1A5 with parity bit 0 -> data=0x1A5, no errors, 8 clk per bit.
